ex_wb_stage: RTL and testbench

EX_WB_STAGE -- requirements
Module: ex_wb_stage

---
 rtl/ex_wb_stage_pkg.sv | 41 ++++
 rtl/ex_wb_stage_if.sv | 36 +++
 rtl/ex_wb_stage.sv | 156 +++++++++++++++
 tb/tb_ex_wb_stage.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_wb_stage_pkg.sv
// Shared definitions for the execute/writeback stage: instruction kinds,
// flush length, FSM state encoding and the branch-condition helper.
package ex_wb_stage_pkg;

   typedef enum logic [1:0] {
      KIND_ALU = 2'b00,
      KIND_BRZ = 2'b01,
      KIND_BRN = 2'b10,
      KIND_JMP = 2'b11
   } kind_e;

   // Width of the flush counter and the number of squash cycles after a redirect
   localparam int              FCNT_W       = 2;
   localparam logic [FCNT_W-1:0] FLUSH_CYCLES = 2'd2;

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_FLUSH = 1'b1
   } state_e;

   // Instruction held in s1 while its ALU result is produced
   typedef struct packed {
      logic        valid;
      kind_e       kind;
      logic [5:0]  rd;
      logic [31:0] target;
   } s1_t;

   // Branch condition evaluated against the architectural flags
   function automatic logic branch_taken(input kind_e kind, input logic z, input logic n);
      logic taken;
      case (kind)
         KIND_JMP: taken = 1'b1;
         KIND_BRZ: taken = z;
         KIND_BRN: taken = n;
         default:  taken = 1'b0;
      endcase
      return taken;
   endfunction

endpackage

// File: rtl/ex_wb_stage_if.sv
// Bundle of the issue, ALU-result and writeback/redirect signals around
// ex_wb_stage. master = upstream/ALU/register-file side, slave = the stage.
interface ex_wb_stage_if;

   logic        ex_valid;
   logic [1:0]  ex_kind;
   logic [5:0]  ex_rd;
   logic [31:0] ex_target;
   logic [31:0] alu_out;
   logic        alu_z;
   logic        alu_n;
   logic        wb_ready;
   logic        wb_valid;
   logic [5:0]  wb_rd;
   logic [31:0] wb_data;
   logic        br_taken;
   logic [31:0] br_target;
   logic        flush;
   logic        stall;
   logic        flag_z;
   logic        flag_n;
   logic [15:0] retire_cnt;

   modport master (
      output ex_valid, ex_kind, ex_rd, ex_target, alu_out, alu_z, alu_n, wb_ready,
      input  wb_valid, wb_rd, wb_data, br_taken, br_target, flush, stall,
             flag_z, flag_n, retire_cnt
   );

   modport slave (
      input  ex_valid, ex_kind, ex_rd, ex_target, alu_out, alu_z, alu_n, wb_ready,
      output wb_valid, wb_rd, wb_data, br_taken, br_target, flush, stall,
             flag_z, flag_n, retire_cnt
   );

endinterface

// File: rtl/ex_wb_stage.sv
// Execute/writeback stage: aligns issued instructions with the 1-cycle ALU
// result, holds a single writeback register with ready/valid backpressure,
// resolves branches against the architectural flags and squashes younger
// instructions for FLUSH_CYCLES after a redirect.
module ex_wb_stage
   import ex_wb_stage_pkg::*;
(
   input  logic        clock,
   input  logic        reset_n,
   input  logic        ex_valid,
   input  logic [1:0]  ex_kind,
   input  logic [5:0]  ex_rd,
   input  logic [31:0] ex_target,
   input  logic [31:0] alu_out,
   input  logic        alu_z,
   input  logic        alu_n,
   input  logic        wb_ready,
   output logic        wb_valid,
   output logic [5:0]  wb_rd,
   output logic [31:0] wb_data,
   output logic        br_taken,
   output logic [31:0] br_target,
   output logic        flush,
   output logic        stall,
   output logic        flag_z,
   output logic        flag_n,
   output logic [15:0] retire_cnt
);

   s1_t              s1_q, s1_d;
   logic             wb_valid_q, wb_valid_d;
   logic [5:0]       wb_rd_q, wb_rd_d;
   logic [31:0]      wb_data_q, wb_data_d;
   logic             flag_z_q, flag_z_d;
   logic             flag_n_q, flag_n_d;
   logic             br_taken_q, br_taken_d;
   logic [31:0]      br_target_q, br_target_d;
   logic [15:0]      retire_q, retire_d;
   state_e           state_q;
   logic [FCNT_W-1:0] fcnt_q;
   logic             flush_q;

   logic             stall_w;
   logic             wb_hs;
   logic             wb_load;
   logic             br_resolve;
   logic             br_take;

   // Writeback register full and not accepted: everything upstream holds
   assign stall_w    = wb_valid_q & ~wb_ready;
   assign wb_hs      = wb_valid_q & wb_ready;
   assign wb_load    = s1_q.valid & (s1_q.kind == KIND_ALU) & ~stall_w;
   assign br_resolve = s1_q.valid & (s1_q.kind != KIND_ALU) & ~stall_w;
   // Flags used here are the pre-edge values; branches never write them
   assign br_take    = br_resolve & branch_taken(s1_q.kind, flag_z_q, flag_n_q);

   // Next state of s1: capture issue unless stalled; drop it in FLUSH or when squashed by a redirect
   always_comb begin
      s1_d = s1_q;
      if (!stall_w) begin
         s1_d.valid  = ex_valid & (state_q == ST_RUN) & ~br_take;
         s1_d.kind   = kind_e'(ex_kind);
         s1_d.rd     = ex_rd;
         s1_d.target = ex_target;
      end
   end

   // Next state of writeback register, flags, redirect pulse and retire counter
   always_comb begin
      wb_valid_d  = wb_valid_q;
      wb_rd_d     = wb_rd_q;
      wb_data_d   = wb_data_q;
      flag_z_d    = flag_z_q;
      flag_n_d    = flag_n_q;
      if (wb_load) begin
         wb_valid_d = 1'b1;
         wb_rd_d    = s1_q.rd;
         wb_data_d  = alu_out;
         flag_z_d   = alu_z;
         flag_n_d   = alu_n;
      end else if (wb_hs) begin
         wb_valid_d = 1'b0;
      end
      br_taken_d  = br_take;
      br_target_d = br_take ? s1_q.target : br_target_q;
      retire_d    = retire_q + 16'(wb_hs) + 16'(br_resolve);
   end

   // Datapath registers
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         s1_q        <= '0;
         wb_valid_q  <= 1'b0;
         wb_rd_q     <= '0;
         wb_data_q   <= '0;
         flag_z_q    <= 1'b0;
         flag_n_q    <= 1'b0;
         br_taken_q  <= 1'b0;
         br_target_q <= '0;
         retire_q    <= '0;
      end else begin
         s1_q        <= s1_d;
         wb_valid_q  <= wb_valid_d;
         wb_rd_q     <= wb_rd_d;
         wb_data_q   <= wb_data_d;
         flag_z_q    <= flag_z_d;
         flag_n_q    <= flag_n_d;
         br_taken_q  <= br_taken_d;
         br_target_q <= br_target_d;
         retire_q    <= retire_d;
      end
   end

   // RUN/FLUSH controller with registered flush output and squash counter
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_RUN;
         fcnt_q  <= '0;
         flush_q <= 1'b0;
      end else begin
         case (state_q)
            ST_RUN: begin
               if (br_take) begin
                  state_q <= ST_FLUSH;
                  fcnt_q  <= FLUSH_CYCLES;
                  flush_q <= 1'b1;
               end
            end
            ST_FLUSH: begin
               fcnt_q <= fcnt_q - 2'd1;
               if (fcnt_q <= 2'd1) begin
                  state_q <= ST_RUN;
                  flush_q <= 1'b0;
               end
            end
            default: begin
               state_q <= ST_RUN;
               fcnt_q  <= '0;
               flush_q <= 1'b0;
            end
         endcase
      end
   end

   assign wb_valid   = wb_valid_q;
   assign wb_rd      = wb_rd_q;
   assign wb_data    = wb_data_q;
   assign br_taken   = br_taken_q;
   assign br_target  = br_target_q;
   assign flush      = flush_q;
   assign stall      = stall_w;
   assign flag_z     = flag_z_q;
   assign flag_n     = flag_n_q;
   assign retire_cnt = retire_q;

endmodule

// File: tb/tb_ex_wb_stage.sv
// Bench for ex_wb_stage: drives issue + a registered ALU model, keeps
// expected writebacks and redirects in queues and checks them as they appear.
module tb_ex_wb_stage;
   import ex_wb_stage_pkg::*;

   typedef struct packed {
      logic [5:0]  rd;
      logic [31:0] data;
   } wb_exp_t;

   logic clock = 1'b0;
   logic reset_n = 1'b0;
   always #5 clock = ~clock;

   ex_wb_stage_if bus();

   ex_wb_stage dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .ex_valid   (bus.ex_valid),
      .ex_kind    (bus.ex_kind),
      .ex_rd      (bus.ex_rd),
      .ex_target  (bus.ex_target),
      .alu_out    (bus.alu_out),
      .alu_z      (bus.alu_z),
      .alu_n      (bus.alu_n),
      .wb_ready   (bus.wb_ready),
      .wb_valid   (bus.wb_valid),
      .wb_rd      (bus.wb_rd),
      .wb_data    (bus.wb_data),
      .br_taken   (bus.br_taken),
      .br_target  (bus.br_target),
      .flush      (bus.flush),
      .stall      (bus.stall),
      .flag_z     (bus.flag_z),
      .flag_n     (bus.flag_n),
      .retire_cnt (bus.retire_cnt)
   );

   int          n_checks = 0;
   int          n_errors = 0;
   int          cyc = 0;
   bit          quiet = 1'b0;
   wb_exp_t     wb_q[$];
   logic [31:0] br_q[$];
   logic [15:0] exp_retire = '0;
   logic        m_z = 1'b0;
   logic        m_n = 1'b0;
   int          sq_lo = 1;
   int          sq_hi = 0;
   int          flush_seen = 0;
   int          exp_flush = 0;
   logic [31:0] alu_next = '0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Registered ALU model: result appears the cycle after issue, holds otherwise
   always @(posedge clock) begin
      cyc <= cyc + 1;
      if (bus.ex_valid && !bus.stall && bus.ex_kind == 2'b00) begin
         bus.alu_out <= alu_next;
         bus.alu_z   <= (alu_next == 32'd0);
         bus.alu_n   <= alu_next[31];
      end
   end

   // Output monitor: writeback handshakes and redirect pulses against the queues
   always @(negedge clock) begin
      if (reset_n) begin
         if (bus.wb_valid && bus.wb_ready) begin
            if (wb_q.size() == 0) begin
               check_eq("wb_unexpected", 32'd1, 32'd0);
            end else begin
               wb_exp_t e;
               e = wb_q.pop_front();
               check_eq("wb_rd", 32'(bus.wb_rd), 32'(e.rd));
               check_eq("wb_data", bus.wb_data, e.data);
               if (!quiet) $display("wb   rd=%0d data=0x%08h retire=%0d", bus.wb_rd, bus.wb_data, bus.retire_cnt);
            end
         end
         if (bus.br_taken) begin
            if (br_q.size() == 0) begin
               check_eq("br_unexpected", 32'd1, 32'd0);
            end else begin
               logic [31:0] t;
               t = br_q.pop_front();
               check_eq("br_target", bus.br_target, t);
               if (!quiet) $display("br   target=0x%08h", bus.br_target);
            end
         end
         if (bus.flush) flush_seen++;
      end
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) step();
   endtask

   // Drive one instruction for one cycle and record what it should produce
   task automatic issue(input kind_e k, input logic [5:0] rd, input logic [31:0] tgt, input logic [31:0] res);
      logic squash;
      logic taken;
      squash        = (cyc >= sq_lo) && (cyc <= sq_hi);
      bus.ex_valid  = 1'b1;
      bus.ex_kind   = k;
      bus.ex_rd     = rd;
      bus.ex_target = tgt;
      alu_next      = res;
      if (!squash) begin
         exp_retire = exp_retire + 16'd1;
         if (k == KIND_ALU) begin
            wb_q.push_back('{rd: rd, data: res});
            m_z = (res == 32'd0);
            m_n = res[31];
         end else begin
            taken = (k == KIND_JMP) || (k == KIND_BRZ && m_z) || (k == KIND_BRN && m_n);
            if (taken) begin
               br_q.push_back(tgt);
               sq_lo     = cyc + 1;
               sq_hi     = cyc + 3;
               exp_flush = exp_flush + 2;
            end
         end
      end
      step();
      bus.ex_valid = 1'b0;
   endtask

   task automatic checkpoint(input string tag);
      @(negedge clock);
      check_eq({tag, "_retire"}, 32'(bus.retire_cnt), 32'(exp_retire));
      check_eq({tag, "_flag_z"}, 32'(bus.flag_z), 32'(m_z));
      check_eq({tag, "_flag_n"}, 32'(bus.flag_n), 32'(m_n));
      check_eq({tag, "_flush_cycles"}, flush_seen, exp_flush);
      $display("chk  %s retire=%0d flags z=%0d n=%0d", tag, bus.retire_cnt, bus.flag_z, bus.flag_n);
   endtask

   task automatic check_all_zero(input string tag);
      check_eq({tag, "_wb_valid"}, 32'(bus.wb_valid), 32'd0);
      check_eq({tag, "_br_taken"}, 32'(bus.br_taken), 32'd0);
      check_eq({tag, "_flush"}, 32'(bus.flush), 32'd0);
      check_eq({tag, "_flag_z"}, 32'(bus.flag_z), 32'd0);
      check_eq({tag, "_flag_n"}, 32'(bus.flag_n), 32'd0);
      check_eq({tag, "_retire"}, 32'(bus.retire_cnt), 32'd0);
      check_eq({tag, "_wb_rd"}, 32'(bus.wb_rd), 32'd0);
      check_eq({tag, "_wb_data"}, bus.wb_data, 32'd0);
      check_eq({tag, "_br_target"}, bus.br_target, 32'd0);
      check_eq({tag, "_stall"}, 32'(bus.stall), 32'd0);
   endtask

   // Watchdog so the run always ends
   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus.ex_valid  = 1'b0;
      bus.ex_kind   = 2'b00;
      bus.ex_rd     = '0;
      bus.ex_target = '0;
      bus.alu_out   = '0;
      bus.alu_z     = 1'b0;
      bus.alu_n     = 1'b0;
      bus.wb_ready  = 1'b1;

      // Reset state
      repeat (2) @(posedge clock);
      @(negedge clock);
      check_all_zero("reset");
      reset_n = 1'b1;
      step();

      // Single ALU op
      issue(KIND_ALU, 6'd5, 32'd0, 32'h0000_0007);
      idle(3);
      checkpoint("single_alu");

      // Backpressure: two back-to-back results, register file busy for 3 cycles
      bus.wb_ready = 1'b0;
      issue(KIND_ALU, 6'd10, 32'd0, 32'h0000_0011);
      issue(KIND_ALU, 6'd11, 32'd0, 32'h8000_0022);
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         check_eq("bp_stall", 32'(bus.stall), 32'd1);
         check_eq("bp_hold_data", bus.wb_data, 32'h0000_0011);
         check_eq("bp_hold_rd", 32'(bus.wb_rd), 32'd10);
         step();
      end
      bus.wb_ready = 1'b1;
      @(negedge clock);
      check_eq("bp_release_stall", 32'(bus.stall), 32'd0);
      step();
      @(negedge clock);
      check_eq("bp_second_next", bus.wb_data, 32'h8000_0022);
      check_eq("bp_second_valid", 32'(bus.wb_valid), 32'd1);
      idle(3);
      checkpoint("backpressure");

      // BRZ taken; the instruction right behind it must be squashed
      issue(KIND_ALU, 6'd1, 32'd0, 32'h0000_0000);
      issue(KIND_BRZ, 6'd0, 32'h0000_0040, 32'd0);
      issue(KIND_ALU, 6'd2, 32'd0, 32'h0000_0099);
      idle(5);
      checkpoint("brz_taken");
      check_eq("brz_target_hold", bus.br_target, 32'h0000_0040);

      // BRN not taken
      issue(KIND_ALU, 6'd3, 32'd0, 32'h0000_0001);
      issue(KIND_BRN, 6'd0, 32'h0000_0080, 32'd0);
      idle(4);
      checkpoint("brn_not_taken");

      // BRN taken after a negative result, then an unconditional jump
      issue(KIND_ALU, 6'd4, 32'd0, 32'hFFFF_FFF0);
      issue(KIND_BRN, 6'd0, 32'h0000_0200, 32'd0);
      idle(5);
      issue(KIND_JMP, 6'd0, 32'h0000_0100, 32'd0);
      idle(5);
      checkpoint("brn_jmp_taken");

      // Retire counter wrap
      quiet = 1'b1;
      while (exp_retire != 16'hFFFF) issue(KIND_ALU, 6'($urandom), 32'd0, $urandom);
      idle(3);
      quiet = 1'b0;
      checkpoint("preload_ffff");
      issue(KIND_ALU, 6'd9, 32'd0, 32'h0000_1234);
      idle(3);
      checkpoint("wrap");

      // Reset asserted in the middle of a flush
      issue(KIND_ALU, 6'd6, 32'd0, 32'h0000_0000);
      issue(KIND_BRZ, 6'd0, 32'h0000_0300, 32'd0);
      step();
      @(negedge clock);
      check_eq("pre_reset_flush", 32'(bus.flush), 32'd1);
      #2;
      reset_n = 1'b0;
      #1;
      check_all_zero("mid_flush_reset");
      wb_q.delete();
      br_q.delete();
      exp_retire = '0;
      m_z        = 1'b0;
      m_n        = 1'b0;
      sq_lo      = 1;
      sq_hi      = 0;
      flush_seen = 0;
      exp_flush  = 0;
      @(posedge clock);
      @(posedge clock);
      #2;
      reset_n = 1'b1;
      issue(KIND_ALU, 6'd7, 32'd0, 32'h8000_1234);
      idle(3);
      checkpoint("after_reset");

      check_eq("wb_queue_drained", wb_q.size(), 32'd0);
      check_eq("br_queue_drained", br_q.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
